// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared sizes, entry record and helpers for the reorder buffer
package rob_pkg;
  localparam int ROB_SIZE   = 64;
  localparam int NUM_REG    = 32;
  localparam int NUM_TAGS   = 64;
  localparam int REG_SIZE   = 32;
  localparam int PC_W       = 32;
  localparam int DISPATCH_W = 2;
  localparam int COMPLETE_W = 4;
  localparam int RETIRE_W   = 2;
  localparam int NUM_SRC    = 2;

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int RD_W  = $clog2(NUM_REG);
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [RD_W-1:0]     rd_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [REG_SIZE-1:0] data_t;
  typedef logic [PC_W-1:0]     pc_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    logic  exc;
    pc_t   pc;
    rd_t   rd;
    tag_t  tag;
    data_t data;
  } rob_entry_t;

  function automatic cnt_t popcount(input logic [DISPATCH_W-1:0] v);
    cnt_t n;
    n = '0;
    for (int i = 0; i < DISPATCH_W; i++) n = n + cnt_t'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rob_if.sv
// rtl/rob_if.sv - dispatch, completion, rollback, forwarding and retire signals of the ROB
interface rob_if;
  import rob_pkg::*;

  logic [DISPATCH_W-1:0]   disp_valid;
  pc_t  [DISPATCH_W-1:0]   disp_pc;
  rd_t  [DISPATCH_W-1:0]   disp_rd;
  tag_t [DISPATCH_W-1:0]   disp_tag;
  logic                    disp_ready;
  idx_t [DISPATCH_W-1:0]   disp_idx;
  logic [COMPLETE_W-1:0]   cmp_valid;
  idx_t [COMPLETE_W-1:0]   cmp_idx;
  data_t [COMPLETE_W-1:0]  cmp_data;
  logic [COMPLETE_W-1:0]   cmp_exc;
  logic                    rb_valid;
  idx_t                    rb_idx;
  tag_t [NUM_SRC-1:0]      src_tag;
  logic [NUM_SRC-1:0]      fwd_hit;
  data_t [NUM_SRC-1:0]     fwd_data;
  logic [RETIRE_W-1:0]     ret_valid;
  rd_t  [RETIRE_W-1:0]     ret_rd;
  tag_t [RETIRE_W-1:0]     ret_tag;
  data_t [RETIRE_W-1:0]    ret_data;
  logic                    exc_valid;
  pc_t                     exc_pc;
  cnt_t                    count;
  logic                    empty;

  modport master (
    output disp_valid, disp_pc, disp_rd, disp_tag, cmp_valid, cmp_idx, cmp_data, cmp_exc,
           rb_valid, rb_idx, src_tag,
    input  disp_ready, disp_idx, fwd_hit, fwd_data, ret_valid, ret_rd, ret_tag, ret_data,
           exc_valid, exc_pc, count, empty
  );

  modport slave (
    input  disp_valid, disp_pc, disp_rd, disp_tag, cmp_valid, cmp_idx, cmp_data, cmp_exc,
           rb_valid, rb_idx, src_tag,
    output disp_ready, disp_idx, fwd_hit, fwd_data, ret_valid, ret_rd, ret_tag, ret_data,
           exc_valid, exc_pc, count, empty
  );
endinterface

// File: rtl/rob_fwd_cam.sv
// rtl/rob_fwd_cam.sv - youngest-match tag lookup over completed entries, aged from head
module rob_fwd_cam
  import rob_pkg::*;
(
  input  logic [ROB_SIZE-1:0] cand,
  input  tag_t                tags [ROB_SIZE],
  input  data_t               vals [ROB_SIZE],
  input  idx_t                head,
  input  tag_t                src_tag,
  output logic                hit,
  output data_t               data
);
  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Walk oldest to youngest so the match nearest the tail is the one left standing.
    for (int off = 0; off < ROB_SIZE; off++) begin
      if (src_tag != '0 && cand[head + idx_t'(off)] && tags[head + idx_t'(off)] == src_tag) begin
        hit  = 1'b1;
        data = vals[head + idx_t'(off)];
      end
    end
  end
endmodule

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - multi-issue reorder buffer with precise flush, rollback and forwarding
module rob_multiport
  import rob_pkg::*;
(
  input logic  clk,
  input logic  rst,
  rob_if.slave bus
);
  rob_entry_t          ent [ROB_SIZE];
  idx_t                head, tail, rb_off;
  cnt_t                count, n_disp, n_ret, n_squash;
  logic                exc_now, disp_ok, ret_chain;
  logic [RETIRE_W-1:0] ret_ok;

  logic [ROB_SIZE-1:0]  fwd_cand;
  tag_t                 fwd_tags [ROB_SIZE];
  data_t                fwd_vals [ROB_SIZE];
  logic [NUM_SRC-1:0]   fwd_hit;
  data_t [NUM_SRC-1:0]  fwd_data;

  assign exc_now  = ent[head].valid && ent[head].done && ent[head].exc;
  assign rb_off   = bus.rb_idx - head;
  assign disp_ok  = ((cnt_t'(ROB_SIZE) - count) >= cnt_t'(DISPATCH_W)) && !bus.rb_valid && !exc_now;
  assign n_disp   = disp_ok ? popcount(bus.disp_valid) : '0;
  assign n_squash = bus.rb_valid ? count - cnt_t'(rb_off) - cnt_t'(1) : '0;

  // Retire lanes stop at the first not-ready entry and never reach past a rollback point.
  always_comb begin
    ret_ok    = '0;
    n_ret     = '0;
    ret_chain = 1'b1;
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_ok[k] = ret_chain && ent[head + idx_t'(k)].valid && ent[head + idx_t'(k)].done
                  && !ent[head + idx_t'(k)].exc && (!bus.rb_valid || idx_t'(k) <= rb_off);
      ret_chain = ret_ok[k];
      n_ret     = n_ret + cnt_t'(ret_ok[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      bus.ret_rd[k]   = ent[head + idx_t'(k)].rd;
      bus.ret_tag[k]  = ent[head + idx_t'(k)].tag;
      bus.ret_data[k] = ent[head + idx_t'(k)].data;
    end
    for (int d = 0; d < DISPATCH_W; d++) bus.disp_idx[d] = tail + idx_t'(d);
  end

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      fwd_cand[i] = ent[i].valid && ent[i].done;
      fwd_tags[i] = ent[i].tag;
      fwd_vals[i] = ent[i].data;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_cam
    rob_fwd_cam u_cam (
      .cand    (fwd_cand),
      .tags    (fwd_tags),
      .vals    (fwd_vals),
      .head    (head),
      .src_tag (bus.src_tag[s]),
      .hit     (fwd_hit[s]),
      .data    (fwd_data[s])
    );
  end

  assign bus.ret_valid  = ret_ok;
  assign bus.exc_valid  = exc_now;
  assign bus.exc_pc     = ent[head].pc;
  assign bus.count      = count;
  assign bus.empty      = (count == '0);
  assign bus.disp_ready = disp_ok;
  assign bus.fwd_hit    = fwd_hit;
  assign bus.fwd_data   = fwd_data;

  // Later clears in this block override completions landing on squashed or flushed entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
    end else begin
      for (int c = 0; c < COMPLETE_W; c++) begin
        if (bus.cmp_valid[c] && ent[bus.cmp_idx[c]].valid) begin
          ent[bus.cmp_idx[c]].done <= 1'b1;
          ent[bus.cmp_idx[c]].data <= bus.cmp_data[c];
          ent[bus.cmp_idx[c]].exc  <= bus.cmp_exc[c];
        end
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (ret_ok[k]) begin
          ent[head + idx_t'(k)].valid <= 1'b0;
          ent[head + idx_t'(k)].done  <= 1'b0;
          ent[head + idx_t'(k)].exc   <= 1'b0;
        end
      end
      head <= head + n_ret[IDX_W-1:0];
      if (exc_now) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          ent[i].valid <= 1'b0;
          ent[i].done  <= 1'b0;
          ent[i].exc   <= 1'b0;
        end
        tail  <= head;
        count <= '0;
      end else begin
        if (bus.rb_valid) begin
          for (int i = 0; i < ROB_SIZE; i++) begin
            if (idx_t'(idx_t'(i) - head) > rb_off) begin
              ent[i].valid <= 1'b0;
              ent[i].done  <= 1'b0;
              ent[i].exc   <= 1'b0;
            end
          end
        end
        for (int d = 0; d < DISPATCH_W; d++) begin
          if (disp_ok && bus.disp_valid[d]) begin
            ent[tail + idx_t'(d)] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0,
                                       pc: bus.disp_pc[d], rd: bus.disp_rd[d],
                                       tag: bus.disp_tag[d], data: '0};
          end
        end
        tail  <= bus.rb_valid ? bus.rb_idx + idx_t'(1) : tail + n_disp[IDX_W-1:0];
        count <= count + n_disp - n_ret - n_squash;
      end
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - randomized ROB bench checked against an in-order queue model
`timescale 1ns/1ps
module tb_rob_multiport;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_if bus();
  rob_multiport dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [PC_W-1:0]     pc;
    int                  rd;
    int                  tag;
    bit                  done;
    bit                  exc;
    logic [REG_SIZE-1:0] data;
  } m_ent_t;

  // Oldest instruction at the front; its ROB index is mhead + position.
  m_ent_t mq[$];
  int     mhead;
  int     n_checks;
  int     n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.disp_valid = '0; bus.disp_pc = '0; bus.disp_rd = '0; bus.disp_tag = '0;
    bus.cmp_valid = '0; bus.cmp_idx = '0; bus.cmp_data = '0; bus.cmp_exc = '0;
    bus.rb_valid = 1'b0; bus.rb_idx = '0; bus.src_tag = '0;
  endtask

  task automatic drive_random(input int cmp_pct, input int exc_pct, input int rb_pct);
    bit taken [ROB_SIZE];
    int n, idx, sz;
    sz = mq.size();
    foreach (taken[i]) taken[i] = 1'b0;
    n = $urandom_range(DISPATCH_W, 0);
    for (int d = 0; d < DISPATCH_W; d++) begin
      bus.disp_valid[d] = (d < n);
      bus.disp_pc[d]    = pc_t'($urandom);
      bus.disp_rd[d]    = rd_t'($urandom_range(NUM_REG - 1, 0));
      bus.disp_tag[d]   = tag_t'($urandom_range(7, 0));
    end
    for (int c = 0; c < COMPLETE_W; c++) begin
      if (sz > 0 && $urandom_range(7, 0) != 0) idx = (mhead + $urandom_range(sz - 1, 0)) % ROB_SIZE;
      else if (sz < ROB_SIZE) idx = (mhead + sz + $urandom_range(ROB_SIZE - sz - 1, 0)) % ROB_SIZE;
      else idx = mhead;
      bus.cmp_valid[c] = 1'b0;
      if (!taken[idx] && $urandom_range(99, 0) < cmp_pct) begin
        taken[idx] = 1'b1;
        bus.cmp_valid[c] = 1'b1;
      end
      bus.cmp_idx[c]  = idx_t'(idx);
      bus.cmp_data[c] = data_t'($urandom);
      bus.cmp_exc[c]  = ($urandom_range(99, 0) < exc_pct);
    end
    bus.rb_valid = (sz > 0) && ($urandom_range(99, 0) < rb_pct);
    bus.rb_idx   = idx_t'((mhead + ((sz > 0) ? $urandom_range(sz - 1, 0) : 0)) % ROB_SIZE);
    for (int s = 0; s < NUM_SRC; s++) bus.src_tag[s] = tag_t'($urandom_range(7, 0));
  endtask

  // Predict and compare this cycle's outputs, take the edge, then advance the model.
  task automatic step();
    int nret, rbpos, p;
    bit exc_p, rdy, hit;
    logic [REG_SIZE-1:0] fd;
    m_ent_t e;
    #1;
    rbpos = bus.rb_valid ? (int'(bus.rb_idx) - mhead + ROB_SIZE) % ROB_SIZE : ROB_SIZE;
    exc_p = (mq.size() > 0) && mq[0].done && mq[0].exc;
    rdy   = (ROB_SIZE - mq.size() >= DISPATCH_W) && !bus.rb_valid && !exc_p;
    nret  = 0;
    while (nret < RETIRE_W && nret < mq.size() && mq[nret].done && !mq[nret].exc && nret <= rbpos)
      nret++;
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
    chk("disp_ready", 64'(bus.disp_ready), 64'(rdy));
    chk("exc_valid", 64'(bus.exc_valid), 64'(exc_p));
    if (exc_p) chk("exc_pc", 64'(bus.exc_pc), 64'(mq[0].pc));
    chk("ret_valid", 64'(bus.ret_valid), 64'((1 << nret) - 1));
    for (int k = 0; k < nret; k++) begin
      chk("ret_rd", 64'(bus.ret_rd[k]), 64'(mq[k].rd));
      chk("ret_tag", 64'(bus.ret_tag[k]), 64'(mq[k].tag));
      chk("ret_data", 64'(bus.ret_data[k]), 64'(mq[k].data));
    end
    for (int d = 0; d < DISPATCH_W; d++)
      chk("disp_idx", 64'(bus.disp_idx[d]), 64'((mhead + mq.size() + d) % ROB_SIZE));
    for (int s = 0; s < NUM_SRC; s++) begin
      hit = 1'b0;
      fd  = '0;
      for (int q = mq.size() - 1; q >= 0; q--) begin
        if (!hit && bus.src_tag[s] != '0 && mq[q].done && int'(bus.src_tag[s]) == mq[q].tag) begin
          hit = 1'b1;
          fd  = mq[q].data;
        end
      end
      chk("fwd_hit", 64'(bus.fwd_hit[s]), 64'(hit));
      chk("fwd_data", 64'(bus.fwd_data[s]), 64'(fd));
    end

    @(posedge clk);
    for (int c = 0; c < COMPLETE_W; c++) begin
      if (bus.cmp_valid[c]) begin
        p = (int'(bus.cmp_idx[c]) - mhead + ROB_SIZE) % ROB_SIZE;
        if (p < mq.size()) begin
          mq[p].done = 1'b1;
          mq[p].data = bus.cmp_data[c];
          mq[p].exc  = bus.cmp_exc[c];
        end
      end
    end
    if (exc_p) mq.delete();
    else begin
      if (bus.rb_valid) while (mq.size() > rbpos + 1) void'(mq.pop_back());
      for (int k = 0; k < nret; k++) void'(mq.pop_front());
      mhead = (mhead + nret) % ROB_SIZE;
      if (rdy) begin
        for (int d = 0; d < DISPATCH_W; d++) begin
          if (bus.disp_valid[d]) begin
            e.pc = bus.disp_pc[d]; e.rd = int'(bus.disp_rd[d]); e.tag = int'(bus.disp_tag[d]);
            e.done = 1'b0; e.exc = 1'b0; e.data = '0;
            mq.push_back(e);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mhead    = 0;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_count", 64'(bus.count), 64'(0));
    chk("reset_empty", 64'(bus.empty), 64'(1));
    chk("reset_ready", 64'(bus.disp_ready), 64'(1));
    chk("reset_exc", 64'(bus.exc_valid), 64'(0));
    chk("reset_ret", 64'(bus.ret_valid), 64'(0));
    rst = 1'b1;

    // Fill to capacity with no completions, then offer one more group.
    for (int i = 0; i <= ROB_SIZE / DISPATCH_W; i++) begin
      idle();
      bus.disp_valid = '1;
      bus.disp_pc[0] = pc_t'(4 * i);
      bus.disp_tag[0] = tag_t'(i % 8);
      step();
    end
    #1;
    chk("full_count", 64'(bus.count), 64'(ROB_SIZE));
    chk("full_ready", 64'(bus.disp_ready), 64'(0));
    chk("full_empty", 64'(bus.empty), 64'(0));

    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 400; i++) begin
        drive_random((seg % 2 == 1) ? 70 : 20, (seg % 3 == 2) ? 2 : 0, 3);
        step();
      end
    end

    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_count", 64'(bus.count), 64'(0));
    chk("midrst_ret", 64'(bus.ret_valid), 64'(0));
    chk("midrst_exc", 64'(bus.exc_valid), 64'(0));
    chk("midrst_ready", 64'(bus.disp_ready), 64'(1));
    mq.delete();
    mhead = 0;
    rst = 1'b1;

    // Two in-flight entries share tag 6; the younger value must be forwarded.
    idle();
    bus.disp_valid = '1;
    bus.disp_tag[0] = tag_t'(6);
    bus.disp_tag[1] = tag_t'(6);
    step();
    idle();
    bus.cmp_valid[0] = 1'b1; bus.cmp_idx[0] = idx_t'(0); bus.cmp_data[0] = data_t'(32'h11);
    bus.cmp_valid[1] = 1'b1; bus.cmp_idx[1] = idx_t'(1); bus.cmp_data[1] = data_t'(32'h22);
    step();
    idle();
    bus.src_tag[0] = tag_t'(6);
    #1;
    chk("fwd_young_hit", 64'(bus.fwd_hit[0]), 64'(1));
    chk("fwd_young_data", 64'(bus.fwd_data[0]), 64'(32'h22));
    chk("fwd_tag0_hit", 64'(bus.fwd_hit[1]), 64'(0));
    step();

    idle();
    bus.disp_valid[0] = 1'b1;
    bus.disp_pc[0] = pc_t'(32'h40);
    step();
    idle();
    bus.cmp_valid[0] = 1'b1; bus.cmp_idx[0] = idx_t'(2); bus.cmp_exc[0] = 1'b1;
    step();
    idle();
    #1;
    chk("exc_pulse", 64'(bus.exc_valid), 64'(1));
    chk("exc_pc_40", 64'(bus.exc_pc), 64'(32'h40));
    chk("exc_no_ret", 64'(bus.ret_valid), 64'(0));
    step();
    #1;
    chk("post_exc_count", 64'(bus.count), 64'(0));
    chk("post_exc_pulse", 64'(bus.exc_valid), 64'(0));
    chk("post_exc_tail", 64'(bus.disp_idx[0]), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
